// File: rtl/display_9_digitos.sv
// Nine-digit multiplexed 7-segment driver for the stopwatch.
// Once per frame it takes a snapshot of the BCD digits and scans them onto
// a common 9-anode display. Every output is registered and active-low.
module display_9_digitos #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [35:0] digitos,
  output logic [8:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [35:0]      snap_q, snap_d;
  logic [8:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [5:0]       shamt;
  logic [3:0]       dig;
  logic             blank_dig;
  logic [6:0]       seg_dec;

  // Select the current digit and decide whether leading-zero blanking applies.
  // Digits idx..8 are all zero exactly when the snapshot shifted down by
  // 4*idx is zero.
  always_comb begin
    shamt     = {idx_q, 2'b00};
    dig       = snap_q[shamt +: 4];
    blank_dig = blank_lz && (idx_q >= 4'd4) && ((snap_q >> shamt) == 36'd0);
  end

  // Convert BCD to active-low gfedcba. Non-BCD nibbles show a dash.
  always_comb begin
    seg_dec = 7'h3F;
    case (dig)
      4'd0: seg_dec = 7'h40;
      4'd1: seg_dec = 7'h79;
      4'd2: seg_dec = 7'h24;
      4'd3: seg_dec = 7'h30;
      4'd4: seg_dec = 7'h19;
      4'd5: seg_dec = 7'h12;
      4'd6: seg_dec = 7'h02;
      4'd7: seg_dec = 7'h78;
      4'd8: seg_dec = 7'h00;
      4'd9: seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  // Advance the slot and digit counters, refresh the snapshot, and compute
  // the next pin values. The output is dark unless we are past the
  // anti-ghosting window of the slot.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    an_d   = 9'h1FF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (!enable) begin
      cnt_d  = '0;
      idx_d  = 4'd0;
      snap_d = digitos;
    end else begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_d = '0;
        if (idx_q == 4'd8) begin
          idx_d  = 4'd0;
          snap_d = digitos;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((cnt_q >= CNT_W'(BLANK_CYC)) && !blank_dig) begin
        an_d  = ~(9'b1 << idx_q);
        seg_d = seg_dec;
        dp_d  = !((idx_q == 4'd3) || (idx_q == 4'd5) || (idx_q == 4'd7));
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 4'd0;
      snap_q <= 36'd0;
      an_q   <= 9'h1FF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_9_digitos.sv
// Directed bench for display_9_digitos with a short slot (8 cycles, 2 dark).
module tb_display_9_digitos;

  localparam int RDIV = 8;
  localparam int BLNK = 2;
  localparam logic [16:0] DARK = {9'h1FF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        blank_lz;
  logic [35:0] digitos;
  logic [8:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_chk = 0;
  int n_err = 0;

  display_9_digitos #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLNK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank_lz(blank_lz),
    .digitos(digitos), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {an,seg,dp}=%05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Check one whole frame starting at the edge that begins slot 0.
  // vis marks which slots are expected lit; optionally changes digitos
  // at cycle 20 of the frame.
  task automatic check_frame(input string tag, input logic [35:0] dgt,
                             input logic [8:0] vis, input bit chg,
                             input logic [35:0] new_dig);
    logic [16:0] exp;
    logic [3:0]  nib;
    logic        dpx;
    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < RDIV; k++) begin
        if (chg && s == 2 && k == 4) digitos = new_dig;
        tick();
        nib = dgt[4*s +: 4];
        dpx = !(s == 3 || s == 5 || s == 7);
        if (k < BLNK || !vis[s]) exp = DARK;
        else exp = {~(9'b1 << s), seg_of(nib), dpx};
        chk($sformatf("%s s%0d c%0d", tag, s, k), {an, seg, dp}, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; blank_lz = 1'b0; digitos = 36'h123456789;
    tick(); tick();
    chk("reset", {an, seg, dp}, DARK);

    // After reset the first frame shows the cleared snapshot.
    rst_n = 1'b1;
    check_frame("rst_frame", 36'h0, 9'h1FF, 1'b0, 36'h0);
    check_frame("frame2", 36'h123456789, 9'h1FF, 1'b0, 36'h0);

    // Load while disabled, change mid-frame: no tearing.
    enable = 1'b0; digitos = 36'h987654321;
    tick();
    chk("disabled", {an, seg, dp}, DARK);
    enable = 1'b1;
    check_frame("load987", 36'h987654321, 9'h1FF, 1'b1, 36'h111111111);
    check_frame("ones", 36'h111111111, 9'h1FF, 1'b0, 36'h0);

    // Leading-zero blanking, then turned off live.
    enable = 1'b0; digitos = 36'h000012340; blank_lz = 1'b1;
    tick();
    enable = 1'b1;
    check_frame("lz_on", 36'h000012340, 9'h01F, 1'b0, 36'h0);
    blank_lz = 1'b0;
    check_frame("lz_off", 36'h000012340, 9'h1FF, 1'b0, 36'h0);

    // Non-BCD nibble on digit 2 shows a dash.
    enable = 1'b0; digitos = 36'h000000A00;
    tick();
    enable = 1'b1;
    check_frame("dash", 36'h000000A00, 9'h1FF, 1'b0, 36'h0);

    // Drop enable mid slot 4.
    enable = 1'b0; digitos = 36'h987654321;
    tick();
    enable = 1'b1;
    repeat (36) tick();
    chk("slot4_lit", {an, seg, dp}, {9'h1EF, 7'h12, 1'b1});
    enable = 1'b0;
    tick();
    chk("en_drop", {an, seg, dp}, DARK);
    enable = 1'b1;
    check_frame("restart", 36'h987654321, 9'h1FF, 1'b0, 36'h0);

    // Reset mid-frame while enabled, then scan restarts from slot 0.
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid", {an, seg, dp}, DARK);
    rst_n = 1'b1;
    check_frame("post_rst", 36'h0, 9'h1FF, 1'b0, 36'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
